// File: rtl/z3_pkg.sv
// Shared Zorro III slave definitions.
// Contents:
//   Z3_IDLE..Z3_BWAIT : FSM state encoding. Plain localparams so older code can share them.
//   z3_dbg_t          : debug snapshot of the FSM, made of state and DATA counter.
//   z3_validspace()   : address-space qualifier taken from the function code.
package z3_pkg;

  localparam logic [2:0] Z3_IDLE  = 3'd0;
  localparam logic [2:0] Z3_START = 3'd1;
  localparam logic [2:0] Z3_DATA  = 3'd2;
  localparam logic [2:0] Z3_END   = 3'd3;
  localparam logic [2:0] Z3_BWAIT = 3'd4;

  localparam int Z3_CNT_W = 10;

  typedef struct packed {
    logic [2:0]          state;
    logic [Z3_CNT_W-1:0] cnt;
  } z3_dbg_t;

  // The slave responds only to user/supervisor data or program space.
  // That is the case when FC[1:0] is 01 or 10.
  function automatic logic z3_validspace(input logic [1:0] fc);
    return fc[1] ^ fc[0];
  endfunction

endpackage

// File: rtl/z3_slave_ctrl_if.sv
// Zorro III bus signals seen by a slave.
// Handshake: the master asserts FCS_n low with A/FC/READ stable, then
// asserts DS_n (writes) while FCS_n is held. The slave answers with dtack,
// and dtack stays high until the master releases FCS_n. mtack advertises
// multi-transfer support during a claimed cycle. The master moves to the
// next burst beat with MTCR_n.
// Ports: FCS_n, DS_n[3:0], MTCR_n, READ, FC[2:0], A[31:0] (master -> slave);
//        dtack, mtack (slave -> master).
interface z3_slave_ctrl_if;
  logic        FCS_n;
  logic [3:0]  DS_n;
  logic        MTCR_n;
  logic        READ;
  logic [2:0]  FC;
  logic [31:0] A;
  logic        dtack;
  logic        mtack;

  modport master (output FCS_n, DS_n, MTCR_n, READ, FC, A,
                  input  dtack, mtack);
  modport slave  (input  FCS_n, DS_n, MTCR_n, READ, FC, A,
                  output dtack, mtack);
endinterface

// File: rtl/z3_sync.sv
// Multi-flop synchroniser for asynchronous active-low strobes.
// Ports: CLK, IORST_n (async, active-low), d[WIDTH-1:0] raw input,
//        q[WIDTH-1:0] synchronised output.
// Reset loads all ones, which is the inactive level for the strobes.
module z3_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             CLK,
  input  logic             IORST_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] sync_q [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '1;
    end else begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/z3_slave_ctrl.sv
// Zorro III slave cycle controller with NUM_WIN address decode windows.
// Ports:
//   CLK, IORST_n            clock and async active-low reset
//   bus                     Zorro III strobes/address, dtack/mtack (slave modport)
//   win_base/win_mask/win_en  per-window A[31:24] base, compare mask, enable
//   tgt_ack                 per-window target-done
//   win_sel                 one-hot selected window (zero when idle)
//   addr_q                  A[31:8] latched at cycle start
//   ds_q                    synchronised data strobes, active high
//   timeout                 one-clock pulse when DATA runs out of time
//   busy                    FSM not idle
//   dbg                     FSM state and DATA counter snapshot
// Build option: define Z3_BURST_EN for multi-transfer (MTCR_n) bursts.
module z3_slave_ctrl
  import z3_pkg::*;
#(
  parameter int NUM_WIN     = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 IORST_n,
  z3_slave_ctrl_if.slave       bus,
  input  logic [NUM_WIN*8-1:0] win_base,
  input  logic [NUM_WIN*8-1:0] win_mask,
  input  logic [NUM_WIN-1:0]   win_en,
  input  logic [NUM_WIN-1:0]   tgt_ack,
  output logic [NUM_WIN-1:0]   win_sel,
  output logic [23:0]          addr_q,
  output logic [3:0]           ds_q,
  output logic                 timeout,
  output logic                 busy,
  output z3_dbg_t              dbg
);

  localparam logic [Z3_CNT_W-1:0] TO_LAST = Z3_CNT_W'(TIMEOUT_CYC - 1);

  logic                fcs_s;
  logic [3:0]          ds_n_s;
  logic [2:0]          state_d, state_q;
  logic [NUM_WIN-1:0]  win_sel_d, win_sel_q;
  logic [23:0]         addr_d;
  logic [Z3_CNT_W-1:0] cnt_d, cnt_q;
  logic [NUM_WIN-1:0]  match_vec, first_sel;
  logic                sel_ack, data_go;
  logic                unused_bits;

  z3_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_fcs (
    .CLK(CLK), .IORST_n(IORST_n), .d(bus.FCS_n), .q(fcs_s));
  z3_sync #(.STAGES(SYNC_STAGES), .WIDTH(4)) u_sync_ds (
    .CLK(CLK), .IORST_n(IORST_n), .d(bus.DS_n), .q(ds_n_s));

`ifdef Z3_BURST_EN
  logic mtcr_s;
  z3_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_mtcr (
    .CLK(CLK), .IORST_n(IORST_n), .d(bus.MTCR_n), .q(mtcr_s));
  assign unused_bits = ^{bus.A[7:0], bus.FC[2]};
`else
  assign unused_bits = ^{bus.A[7:0], bus.FC[2], bus.MTCR_n};
`endif

  assign ds_q = ~ds_n_s;

  // Window decode. The lowest matching index wins, so win_sel stays one-hot.
  always_comb begin
    match_vec = '0;
    first_sel = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      match_vec[i] = win_en[i] &&
        (((bus.A[31:24] ^ win_base[i*8 +: 8]) & win_mask[i*8 +: 8]) == 8'h00);
    end
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        first_sel    = '0;
        first_sel[i] = 1'b1;
      end
    end
  end

  assign sel_ack = |(tgt_ack & win_sel_q);
  assign data_go = bus.READ || (|ds_q);

  always_comb begin
    state_d   = state_q;
    win_sel_d = win_sel_q;
    addr_d    = addr_q;
    cnt_d     = '0;
    case (state_q)
      Z3_IDLE: begin
        win_sel_d = '0;
        // A is stable while FCS_n is asserted. Re-latching it during an
        // unclaimed cycle therefore holds the value from the falling edge.
        if (!fcs_s) begin
          addr_d = bus.A[31:8];
          if ((|match_vec) && z3_validspace(bus.FC[1:0])) begin
            state_d   = Z3_START;
            win_sel_d = first_sel;
          end
        end
      end
      Z3_START: if (data_go) state_d = Z3_DATA;
      Z3_DATA: begin
        // Ack is tested first, so an ack on the last counted clock ends
        // the cycle normally and no timeout is flagged.
        if (sel_ack || (cnt_q == TO_LAST)) state_d = Z3_END;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      Z3_END: begin
`ifdef Z3_BURST_EN
        if (mtcr_s) state_d = Z3_BWAIT;
`endif
      end
      Z3_BWAIT: begin
`ifdef Z3_BURST_EN
        if (!mtcr_s && data_go) state_d = Z3_DATA;
`else
        state_d = Z3_IDLE;
`endif
      end
      default: state_d = Z3_IDLE;
    endcase
    // A master release of FCS_n overrides everything else.
    if ((state_q != Z3_IDLE) && fcs_s) begin
      state_d   = Z3_IDLE;
      win_sel_d = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q   <= Z3_IDLE;
      win_sel_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      win_sel_q <= win_sel_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
    end
  end

  // The timeout is combinational so that it is high on the last DATA clock.
  // dtack then follows on the next clock.
  assign timeout   = (state_q == Z3_DATA) && (cnt_q == TO_LAST) && !sel_ack && !fcs_s;
  assign win_sel   = win_sel_q;
  assign busy      = (state_q != Z3_IDLE);
  assign bus.dtack = (state_q == Z3_END);
`ifdef Z3_BURST_EN
  assign bus.mtack = (state_q != Z3_IDLE);
`else
  assign bus.mtack = 1'b0;
`endif
  assign dbg = '{state: state_q, cnt: cnt_q};

endmodule
